// File: rtl/gtx_rx_align_if.sv
// Raw GTX receive word in, byte-aligned word out, plus link status.
// The master drives the raw side; the aligner is the slave.
interface gtx_rx_align_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANES  = 2;
  localparam int unsigned CNT_W  = 16;

  logic [LANES-1:0]  ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic [LANES-1:0]  err_i;
  logic [LANES-1:0]  ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              lock_o;
  logic              align_o;
  logic [CNT_W-1:0]  err_cnt_o;

  modport master (
    output ctrl_i, data_i, err_i,
    input  ctrl_o, data_o, valid_o, lock_o, align_o, err_cnt_o
  );

  modport slave (
    input  ctrl_i, data_i, err_i,
    output ctrl_o, data_o, valid_o, lock_o, align_o, err_cnt_o
  );
endinterface

// File: rtl/gtx_rx_align.sv
// K28.5 word aligner and link-lock qualifier for a 2-byte GTX receive path.
// Moves the comma into byte 0 and counts words carrying 8b10b errors.
module gtx_rx_align #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  gtx_rx_align_if.slave rx
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LANES   = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned ERR_W   = 16;

  localparam logic [BYTE_W-1:0]  K28_5      = 8'hBC;
  localparam logic [CNT_W-1:0]   LOCK_TGT   = CNT_W'(LOCK_CNT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                cand_q,      cand_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                off_q,       off_d;
  logic [TIMER_W-1:0]  timer_q,     timer_d;
  logic [BYTE_W-1:0]   prev_data_q, prev_data_d;
  logic                prev_ctrl_q, prev_ctrl_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic [LANES-1:0]    ctrl_q,      ctrl_d;
  logic                valid_q,     valid_d;
  logic                lock_q,      lock_d;
  logic [ERR_W-1:0]    err_cnt_q,   err_cnt_d;

  logic c0_c;
  logic c1_c;
  logic comma_c;
  logic lane_c;
  logic expired_c;

  // Comma detection; lane 0 wins when both bytes carry K28.5.
  always_comb begin
    c0_c      = rx.ctrl_i[0] && (rx.data_i[BYTE_W-1:0] == K28_5);
    c1_c      = rx.ctrl_i[1] && (rx.data_i[DATA_W-1:BYTE_W] == K28_5);
    comma_c   = c0_c || c1_c;
    lane_c    = !c0_c;
    expired_c = (timer_q == TIMER_LAST) && !comma_c;
  end

  // Gap timer: restarts on every comma and is parked while hunting.
  always_comb begin
    timer_d = timer_q;
    if (comma_c || (state_q == ST_HUNT)) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Lock state machine; the offset is only committed on entry to LOCKED.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    case (state_q)
      ST_HUNT: begin
        if (comma_c) begin
          cand_d  = lane_c;
          cnt_d   = CNT_W'(1);
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (comma_c) begin
          if (lane_c == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == LOCK_TGT) begin
              state_d = ST_LOCKED;
              off_d   = cand_q;
            end
          end else begin
            cand_d = lane_c;
            cnt_d  = CNT_W'(1);
          end
        end else if (expired_c) begin
          state_d = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if ((comma_c && (lane_c != off_q)) || expired_c) begin
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Realignment mux follows the next offset so the locking word is already aligned.
  always_comb begin
    prev_data_d = rx.data_i[DATA_W-1:BYTE_W];
    prev_ctrl_d = rx.ctrl_i[1];
    if (off_d) begin
      data_d = {rx.data_i[BYTE_W-1:0], prev_data_q};
      ctrl_d = {rx.ctrl_i[0], prev_ctrl_q};
    end else begin
      data_d = rx.data_i;
      ctrl_d = rx.ctrl_i;
    end
    valid_d   = (state_d == ST_LOCKED);
    lock_d    = (state_d == ST_LOCKED);
    err_cnt_d = err_cnt_q;
    if ((|rx.err_i) && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      cand_q      <= 1'b0;
      cnt_q       <= '0;
      off_q       <= 1'b0;
      timer_q     <= '0;
      prev_data_q <= '0;
      prev_ctrl_q <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      timer_q     <= timer_d;
      prev_data_q <= prev_data_d;
      prev_ctrl_q <= prev_ctrl_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx.data_o    = data_q;
  assign rx.ctrl_o    = ctrl_q;
  assign rx.valid_o   = valid_q;
  assign rx.lock_o    = lock_q;
  assign rx.align_o   = off_q;
  assign rx.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_gtx_rx_align.sv
// Bench for gtx_rx_align: directed lock/unlock scenarios plus random traffic,
// compared every cycle against a cycle-stamp based reference model.
module tb_gtx_rx_align;

  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned TIMEOUT  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gtx_rx_align_if bus ();

  gtx_rx_align #(
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: link described by run length of same-lane commas and the
  // cycle stamp of the last comma, rather than a gap timer.
  bit          m_locked;
  int          m_run_len;
  bit          m_run_lane;
  bit          m_off;
  int          m_cyc;
  int          m_last;
  logic [7:0]  m_prev_d;
  bit          m_prev_c;
  int          m_err;
  logic [15:0] e_data;
  logic [1:0]  e_ctrl;

  task automatic model_step(input bit r, input logic [1:0] c, input logic [15:0] d,
                            input logic [1:0] e);
    bit c0, c1, comma, lane, hunting, expired;
    if (r) begin
      m_locked = 0; m_run_len = 0; m_run_lane = 0; m_off = 0;
      m_prev_d = 8'h00; m_prev_c = 0; m_err = 0;
      e_data = 16'h0000; e_ctrl = 2'b00;
    end else begin
      c0      = c[0] && (d[7:0] == 8'hBC);
      c1      = c[1] && (d[15:8] == 8'hBC);
      comma   = c0 || c1;
      lane    = c0 ? 1'b0 : 1'b1;
      hunting = !m_locked && (m_run_len == 0);
      expired = !hunting && !comma && ((m_cyc - m_last) == int'(TIMEOUT));
      if (m_locked) begin
        if ((comma && lane != m_off) || expired) begin
          m_locked = 0;
          m_run_len = 0;
        end
      end else if (m_run_len == 0) begin
        if (comma) begin
          m_run_lane = lane;
          m_run_len = 1;
        end
      end else if (comma) begin
        if (lane == m_run_lane) begin
          m_run_len++;
          if (m_run_len == int'(LOCK_CNT)) begin
            m_locked = 1;
            m_off = m_run_lane;
          end
        end else begin
          m_run_lane = lane;
          m_run_len = 1;
        end
      end else if (expired) begin
        m_run_len = 0;
      end
      if (comma) m_last = m_cyc;
      if ((e != 2'b00) && (m_err < 65535)) m_err++;
      if (m_off) begin
        e_data = {d[7:0], m_prev_d};
        e_ctrl = {c[0], m_prev_c};
      end else begin
        e_data = d;
        e_ctrl = c;
      end
      m_prev_d = d[15:8];
      m_prev_c = c[1];
    end
    m_cyc++;
  endtask

  task automatic check_all();
    check("data_o",    32'(bus.data_o),    32'(e_data));
    check("ctrl_o",    32'(bus.ctrl_o),    32'(e_ctrl));
    check("valid_o",   32'(bus.valid_o),   32'(m_locked));
    check("lock_o",    32'(bus.lock_o),    32'(m_locked));
    check("align_o",   32'(bus.align_o),   32'(m_off));
    check("err_cnt_o", 32'(bus.err_cnt_o), 32'(m_err));
  endtask

  task automatic cycle(input bit r, input logic [1:0] c, input logic [15:0] d,
                       input logic [1:0] e, input bit chk);
    rst        = r;
    bus.ctrl_i = c;
    bus.data_i = d;
    bus.err_i  = e;
    model_step(r, c, d, e);
    @(posedge clk);
    #1;
    if (chk) check_all();
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  task automatic data_gap(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, rnd16(), 2'b00, 1'b1);
  endtask

  task automatic comma(input bit lane);
    if (lane) cycle(1'b0, 2'b10, 16'hBC55, 2'b00, 1'b1);
    else      cycle(1'b0, 2'b01, 16'h00BC, 2'b00, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b1, 2'b01, 16'h00BC, 2'b11, 1'b1);
  endtask

  initial begin
    logic [1:0] errs [5];
    bit         bias;
    bit         quiet;
    int         r;
    logic [1:0] c;
    logic [15:0] d;
    logic [1:0] e;

    m_cyc = 0;
    m_last = 0;
    bus.ctrl_i = 2'b00;
    bus.data_i = 16'h0000;
    bus.err_i  = 2'b00;

    // Reset with a comma and errors present: reset must win.
    repeat (3) do_reset();
    check("rst_data",  32'(bus.data_o),    32'h0);
    check("rst_lock",  32'(bus.lock_o),    32'h0);
    check("rst_errc",  32'(bus.err_cnt_o), 32'h0);

    // Lock at lane 0, commas every 16 cycles.
    for (int k = 1; k <= 4; k++) begin
      comma(1'b0);
      check("l0_lock", 32'(bus.lock_o), (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) begin
        check("l0_align", 32'(bus.align_o), 32'h0);
        check("l0_data",  32'(bus.data_o),  32'h00BC);
      end
      data_gap(15);
    end
    check("l0_held", 32'(bus.lock_o), 32'h1);

    // Misaligned comma drops the lock on the next edge.
    comma(1'b1);
    check("mis_lock",  32'(bus.lock_o),  32'h0);
    check("mis_valid", 32'(bus.valid_o), 32'h0);

    // Lane 1 realignment.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      comma(1'b1);
      if (k == 4) begin
        check("l1_lock",  32'(bus.lock_o),  32'h1);
        check("l1_align", 32'(bus.align_o), 32'h1);
      end
      cycle(1'b0, 2'b00, 16'h3412, 2'b00, 1'b1);
      if (k == 4) begin
        check("l1_word0", 32'(bus.data_o), 32'h12BC);
        check("l1_ctrl0", 32'(bus.ctrl_o), 32'h1);
      end
      cycle(1'b0, 2'b00, 16'h7856, 2'b00, 1'b1);
      if (k == 4) check("l1_word1", 32'(bus.data_o), 32'h5634);
      data_gap(8);
    end

    // Candidate restart: 3 at lane 0, then 4 at lane 1.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      comma(1'b0);
      data_gap(5);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) data_gap(5);
      comma(1'b1);
      check("rs_lock", 32'(bus.lock_o), (k == 4) ? 32'h1 : 32'h0);
    end
    check("rs_align", 32'(bus.align_o), 32'h1);

    // Comma starvation: lock holds for 63 empty cycles, drops after the 64th.
    data_gap(63);
    check("to_hold", 32'(bus.lock_o), 32'h1);
    data_gap(1);
    check("to_drop", 32'(bus.lock_o), 32'h0);

    // Reset while locked, then a fresh relock.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      comma(1'b0);
      data_gap(5);
    end
    check("pre_rst_lock", 32'(bus.lock_o), 32'h1);
    do_reset();
    check("mid_rst_lock",  32'(bus.lock_o),  32'h0);
    check("mid_rst_valid", 32'(bus.valid_o), 32'h0);
    check("mid_rst_data",  32'(bus.data_o),  32'h0);
    for (int k = 1; k <= 4; k++) begin
      comma(1'b0);
      check("relock", 32'(bus.lock_o), (k == 4) ? 32'h1 : 32'h0);
      data_gap(3);
    end

    // Random traffic with lane bias, quiet stretches, errors and rare resets.
    bias = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 200) == 0) bias = 1'($urandom_range(0, 1));
      quiet = (i % 500) >= 420;
      r = int'($urandom_range(0, 99));
      d = rnd16();
      c = 2'($urandom_range(0, 3));
      if (!quiet && r < 12) begin
        if (bias) begin d[15:8] = 8'hBC; c[1] = 1'b1; end
        else      begin d[7:0]  = 8'hBC; c[0] = 1'b1; end
      end else if (!quiet && r < 15) begin
        if (bias) begin d[7:0]  = 8'hBC; c[0] = 1'b1; end
        else      begin d[15:8] = 8'hBC; c[1] = 1'b1; end
      end else if (!quiet && r < 17) begin
        d = 16'hBCBC;
        c = 2'b11;
      end else if (quiet) begin
        c = 2'b00;
      end
      e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(($urandom_range(0, 999) == 0), c, d, e, 1'b1);
    end

    // Error counter: five mixed-lane error words, then saturation.
    do_reset();
    errs = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    foreach (errs[i]) cycle(1'b0, 2'b00, rnd16(), errs[i], 1'b1);
    check("err_five", 32'(bus.err_cnt_o), 32'd5);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 2'b00, 16'h0000, 2'b10, 1'b0);
    cycle(1'b0, 2'b00, 16'h0000, 2'b01, 1'b1);
    check("err_sat", 32'(bus.err_cnt_o), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
